// File: rtl/simon_host_driver_if.sv
// Host and core-side signal bundle for the SIMON 64/128 host driver.
// master = the driver itself, slave = the host/core environment around it.
interface simon_host_driver_if #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
);
  logic [M-1:0][N-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic [1:0][N-1:0]   blk_in;
  logic                blk_enc;
  logic                blk_valid;
  logic                blk_ready;
  logic [1:0][N-1:0]   res_out;
  logic                res_valid;
  logic                res_ready;
  logic                busy;
  logic                error;
  logic                newKey;
  logic                newData;
  logic                readData;
  logic                enc_dec;
  logic [M-1:0][N-1:0] KEY;
  logic [1:0][N-1:0]   blockIN;
  logic                loadKey;
  logic                loadData;
  logic                doneKey;
  logic                doneData;
  logic [1:0][N-1:0]   outData;

  modport master (
    input  key_in, key_valid, blk_in, blk_enc, blk_valid, res_ready,
           loadKey, loadData, doneKey, doneData, outData,
    output key_ready, blk_ready, res_out, res_valid, busy, error,
           newKey, newData, readData, enc_dec, KEY, blockIN
  );

  modport slave (
    output key_in, key_valid, blk_in, blk_enc, blk_valid, res_ready,
           loadKey, loadData, doneKey, doneData, outData,
    input  key_ready, blk_ready, res_out, res_valid, busy, error,
           newKey, newData, readData, enc_dec, KEY, blockIN
  );
endinterface

// File: rtl/simon_host_driver.sv
// Host-side initiator for one SIMON 64/128 core: loads keys, streams blocks
// through the core's newKey/newData/readData handshake, and watchdogs each wait.
module simon_host_driver #(
  parameter int unsigned N    = 32,
  parameter int unsigned M    = 4,
  parameter int unsigned TW   = 8,
  parameter int unsigned TMAX = 255
) (
  input logic                 clk,
  input logic                 R,
  simon_host_driver_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, READ, ERR
  } state_t;

  state_t              state;
  logic                key_loaded;
  logic                res_valid_q;
  logic                error_q;
  logic                new_key_q;
  logic                new_data_q;
  logic                read_data_q;
  logic                enc_dec_q;
  logic [M-1:0][N-1:0] key_q;
  logic [1:0][N-1:0]   block_q;
  logic [1:0][N-1:0]   res_q;
  logic [TW-1:0]       wd_cnt;

  logic idle;
  logic blk_rdy;
  logic wd_expired;
  logic key_acc;
  logic blk_acc;

  // A key offered alongside a block takes priority, so blocks wait on !key_valid.
  assign idle       = (state == IDLE);
  assign blk_rdy    = idle && key_loaded && !res_valid_q && !bus.key_valid;
  assign wd_expired = (wd_cnt == TW'(TMAX));
  assign key_acc    = idle && bus.key_valid;
  assign blk_acc    = blk_rdy && bus.blk_valid;

  assign bus.key_ready = idle;
  assign bus.blk_ready = blk_rdy;
  assign bus.busy      = !idle;
  assign bus.res_out   = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.error     = error_q;
  assign bus.newKey    = new_key_q;
  assign bus.newData   = new_data_q;
  assign bus.readData  = read_data_q;
  assign bus.enc_dec   = enc_dec_q;
  assign bus.KEY       = key_q;
  assign bus.blockIN   = block_q;

  // Control FSM with registered strobes; watchdog counter is rezeroed on every phase entry.
  always_ff @(posedge clk) begin
    if (R) begin
      state       <= IDLE;
      key_loaded  <= 1'b0;
      res_valid_q <= 1'b0;
      error_q     <= 1'b0;
      new_key_q   <= 1'b0;
      new_data_q  <= 1'b0;
      read_data_q <= 1'b0;
      enc_dec_q   <= 1'b0;
      key_q       <= '0;
      block_q     <= '0;
      res_q       <= '0;
      wd_cnt      <= '0;
    end else begin
      wd_cnt <= wd_cnt + TW'(1);
      if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (key_acc) begin
            key_q      <= bus.key_in;
            key_loaded <= 1'b0;
            new_key_q  <= 1'b1;
            wd_cnt     <= '0;
            state      <= KEY_REQ;
          end else if (blk_acc) begin
            block_q    <= bus.blk_in;
            enc_dec_q  <= bus.blk_enc;
            new_data_q <= 1'b1;
            wd_cnt     <= '0;
            state      <= DATA_REQ;
          end
        end

        KEY_REQ: begin
          if (bus.loadKey) begin
            new_key_q <= 1'b0;
            wd_cnt    <= '0;
            state     <= KEY_WAIT;
          end else if (wd_expired) begin
            new_key_q  <= 1'b0;
            key_loaded <= 1'b0;
            error_q    <= 1'b1;
            state      <= ERR;
          end
        end

        KEY_WAIT: begin
          if (bus.doneKey) begin
            key_loaded <= 1'b1;
            state      <= IDLE;
          end else if (wd_expired) begin
            key_loaded <= 1'b0;
            error_q    <= 1'b1;
            state      <= ERR;
          end
        end

        DATA_REQ: begin
          if (bus.loadData) begin
            new_data_q <= 1'b0;
            wd_cnt     <= '0;
            state      <= DATA_WAIT;
          end else if (wd_expired) begin
            new_data_q <= 1'b0;
            key_loaded <= 1'b0;
            error_q    <= 1'b1;
            state      <= ERR;
          end
        end

        DATA_WAIT: begin
          if (bus.doneData) begin
            res_q       <= bus.outData;
            res_valid_q <= 1'b1;
            read_data_q <= 1'b1;
            state       <= READ;
          end else if (wd_expired) begin
            key_loaded <= 1'b0;
            error_q    <= 1'b1;
            state      <= ERR;
          end
        end

        READ: begin
          read_data_q <= 1'b0;
          state       <= IDLE;
        end

        ERR: begin
          new_key_q   <= 1'b0;
          new_data_q  <= 1'b0;
          read_data_q <= 1'b0;
          key_loaded  <= 1'b0;
          error_q     <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
